data_mem_split: RTL and testbench
=================================

DATA_MEM_SPLIT -- requirements
Module: data_mem_split

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning data and word width in bits; only 32 and 64 are legal.
REQ-002 SHALL have parameter DEPTH, default 8, meaning storage size in XLEN-bit words; must be a power of 2.
REQ-003 SHALL have parameter ADDR_W, default 64, meaning byte-address width.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, with ports as follows:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
REQ-005 SHALL provide the following request ports:
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double.
- req_unsigned  in  1  zero-extend loads.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, LSB-aligned.
REQ-006 SHALL provide the following response ports:
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  XLEN  load result, extended.
- rsp_err  out  1  access rejected.

Function
REQ-007 SHALL store data as DEPTH words of XLEN bits with per-byte write enables; the byte space is LIMIT = DEPTH*XLEN/8 bytes.
REQ-008 SHALL be little-endian: byte k of an access goes to address req_addr+k.
REQ-009 SHALL implement FSM states IDLE, SECOND and RESP.
REQ-010 SHALL drive req_ready=1 only in IDLE; a request is accepted on a rising edge where req_valid && req_ready.
REQ-011 SHALL compute nbytes = 1<<req_size and SHALL flag an error if nbytes > XLEN/8, or if req_addr+nbytes-1 >= LIMIT (evaluated without overflow), or if ADDR_W-bit wrap occurs.
REQ-012 SHALL handle an errored request as follows:
- no storage is modified;
- the FSM goes IDLE->RESP;
- rsp_err=1 and rsp_rdata=0.
REQ-013 SHALL handle an aligned access (within one word) as follows:
- store bytes are written on the accept edge;
- load data is captured on the accept edge;
- the FSM goes IDLE->RESP, so rsp_valid rises 1 cycle after acceptance.
REQ-014 SHALL treat an access crossing a word boundary per the DMEM_SPLIT_EN rules in Configuration.
REQ-015 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_valid && rsp_ready, then return RESP->IDLE; no request is accepted in the same cycle.
REQ-016 SHALL return a store response with rsp_rdata=0 and rsp_err=0.
REQ-017 SHALL sign-extend a load from bit 8*nbytes-1 unless req_unsigned=1, in which case it zero-extends; a full-width load ignores req_unsigned.
REQ-018 SHALL make a store accepted on edge N visible to a load accepted on any later edge.
REQ-019 SHALL register all request fields on acceptance; inputs are ignored outside IDLE.

Reset
REQ-020 SHALL, on reset_n=0, immediately set state=IDLE, rsp_valid=0, rsp_rdata=0 and rsp_err=0; req_ready is 1 after reset.
REQ-021 SHALL NOT clear storage on reset; contents are preserved.
REQ-022 SHALL, if reset occurs in SECOND, abort the access: the first-word bytes already written remain, the second-word bytes are not written, and no response is issued.

Configuration
REQ-023 SHALL support the macro DATA_MEM_SPLIT_EN, which selects one of two behaviours:
- Defined: a word-crossing access performs the first-word part on the accept edge, goes IDLE->SECOND, performs the second-word part on the next edge, then goes SECOND->RESP, so rsp_valid rises 2 cycles after acceptance; load bytes from both words are merged before extension.
- Undefined: a word-crossing access is an error per REQ-012, SECOND is unreachable, and the split logic is absent.

Structure
REQ-024 SHALL place the size encoding constants (SZ_B/SZ_H/SZ_W/SZ_D) and the FSM state enum in shared package data_mem_pkg.
REQ-025 SHALL contain one sub-module, data_mem_align (combinational), which produces:
- the byte-enable mask and shifted write data for the first and second words;
- the merged, shifted and extended load result.

Verification
REQ-026 SHALL be verified with the following directed scenarios (XLEN=64, DEPTH=8):
- Store double 0x1122334455667788 at 8, then load double at 8 -> rsp_rdata=0x1122334455667788, rsp_err=0, rsp_valid 1 cycle after accept.
- Store byte 0x80 at 16, then load byte signed at 16 -> 0xFFFFFFFFFFFFFF80; load byte unsigned at 16 -> 0x0000000000000080.
- Load double at 60 -> rsp_err=1, rsp_rdata=0, storage unchanged.
- With DATA_MEM_SPLIT_EN, store word 0xAABBCCDD at 6, then load word unsigned at 6 -> 0x00000000AABBCCDD with rsp_valid 2 cycles after accept; without the macro -> rsp_err=1 and bytes 6..9 unchanged.
- Hold rsp_ready=0 for 3 cycles -> rsp_valid/rsp_rdata stable, req_ready=0 throughout; rsp_ready=1 -> IDLE next cycle.
- Assert reset_n=0 while in SECOND during a split store at 6 -> bytes 6..7 updated, bytes 8..9 unchanged, rsp_valid=0.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared constants for data_mem_split: access size encodings and FSM states.
package data_mem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SECOND = 2'd1,
    RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/data_mem_split_if.sv
// Request/response bus of data_mem_split. master = requester, slave = memory.
interface data_mem_split_if #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned ADDR_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [XLEN-1:0]   rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_align.sv
// Byte-lane alignment for data_mem_split. Treats the addressed word and the
// following word as one 2*XLEN window: builds byte enables and shifted store
// data for both words, and merges/shifts/extends load data from both words.
module data_mem_align
  import data_mem_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [$clog2(XLEN/8)-1:0] off,
  input  logic [1:0]                size,
  input  logic                      is_unsigned,
  input  logic [XLEN-1:0]           wdata,
  input  logic [XLEN-1:0]           rdata_lo,
  input  logic [XLEN-1:0]           rdata_hi,
  output logic [XLEN/8-1:0]         be_lo,
  output logic [XLEN/8-1:0]         be_hi,
  output logic [XLEN-1:0]           wdata_lo,
  output logic [XLEN-1:0]           wdata_hi,
  output logic [XLEN-1:0]           ld_data
);
  localparam int unsigned NB = XLEN / 8;

  logic [NB-1:0]     mask;
  logic [2*NB-1:0]   be_full;
  logic [2*XLEN-1:0] wdata_full;
  logic [2*XLEN-1:0] rdata_full;
  logic [XLEN-1:0]   raw;
  logic              ext_bit;
  int                nbits;

  // Lane masks, store shifting and load merge/extension.
  always_comb begin
    unique case (size)
      SZ_B:    mask = NB'(8'h01);
      SZ_H:    mask = NB'(8'h03);
      SZ_W:    mask = NB'(8'h0F);
      default: mask = NB'(8'hFF);
    endcase
    be_full    = {{NB{1'b0}}, mask} << off;
    wdata_full = {{XLEN{1'b0}}, wdata} << {off, 3'b000};
    rdata_full = {rdata_hi, rdata_lo} >> {off, 3'b000};
    be_lo      = be_full[NB-1:0];
    be_hi      = be_full[2*NB-1:NB];
    wdata_lo   = wdata_full[XLEN-1:0];
    wdata_hi   = wdata_full[2*XLEN-1:XLEN];
    raw        = rdata_full[XLEN-1:0];

    // Oversized accesses are rejected upstream; clamp so indexing stays legal.
    nbits = 8 << size;
    if (nbits > int'(XLEN)) nbits = int'(XLEN);
    ext_bit = 1'b0;
    for (int i = 0; i < int'(XLEN); i++) begin
      if (i == nbits - 1) ext_bit = raw[i] & ~is_unsigned;
    end
    ld_data = raw;
    for (int i = 0; i < int'(XLEN); i++) begin
      if (i >= nbits) ld_data[i] = ext_bit;
    end
  end

endmodule

// File: rtl/data_mem_split.sv
// Byte-addressable little-endian data memory with a valid/ready request bus.
// Optional macro DATA_MEM_SPLIT_EN: when defined, accesses crossing a word
// boundary take an extra SECOND cycle; when undefined they are rejected.
module data_mem_split
  import data_mem_pkg::*;
#(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 64
) (
  input logic             clk,
  input logic             reset_n,
  data_mem_split_if.slave bus
);
  localparam int unsigned NB    = XLEN / 8;
  localparam int unsigned OFFW  = $clog2(NB);
  localparam int unsigned IDXW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LIMIT = DEPTH * NB;

  logic [XLEN-1:0] mem [DEPTH];
  state_e          state_q, state_d;
  logic [XLEN-1:0] rsp_rdata_q;
  logic            rsp_err_q;

  logic [OFFW-1:0] req_off;
  logic [IDXW-1:0] req_idx;
  logic [ADDR_W:0] end_addr;
  logic            accept, err, crosses, size_err;

  logic [OFFW-1:0] a_off;
  logic [1:0]      a_size;
  logic            a_uns;
  logic [XLEN-1:0] a_wdata, a_lo, a_hi;
  logic [NB-1:0]   be_lo, be_hi;
  logic [XLEN-1:0] wdata_lo, wdata_hi, ld_data;

`ifdef DATA_MEM_SPLIT_EN
  logic            sec_write_q;
  logic [1:0]      sec_size_q;
  logic            sec_uns_q;
  logic [OFFW-1:0] sec_off_q;
  logic [IDXW-1:0] sec_idx_q;
  logic [XLEN-1:0] sec_wdata_q;
  logic [XLEN-1:0] sec_lo_q;
`else
  logic unused_hi;
  assign unused_hi = ^wdata_hi;
`endif

  assign req_off = bus.req_addr[OFFW-1:0];
  assign req_idx = bus.req_addr[OFFW +: IDXW];
  assign accept  = bus.req_valid && (state_q == IDLE);

  // Align inputs come from the live request in IDLE, from the saved one in SECOND.
  always_comb begin
    a_off   = req_off;
    a_size  = bus.req_size;
    a_uns   = bus.req_unsigned;
    a_wdata = bus.req_wdata;
    a_lo    = mem[req_idx];
    a_hi    = '0;
`ifdef DATA_MEM_SPLIT_EN
    if (state_q == SECOND) begin
      a_off   = sec_off_q;
      a_size  = sec_size_q;
      a_uns   = sec_uns_q;
      a_wdata = sec_wdata_q;
      a_lo    = sec_lo_q;
      a_hi    = mem[sec_idx_q];
    end
`endif
  end

  data_mem_align #(.XLEN(XLEN)) u_align (
    .off        (a_off),
    .size       (a_size),
    .is_unsigned(a_uns),
    .wdata      (a_wdata),
    .rdata_lo   (a_lo),
    .rdata_hi   (a_hi),
    .be_lo      (be_lo),
    .be_hi      (be_hi),
    .wdata_lo   (wdata_lo),
    .wdata_hi   (wdata_hi),
    .ld_data    (ld_data)
  );

  // Request checks; the extra address bit catches ADDR_W wrap-around.
  always_comb begin
    end_addr = {1'b0, bus.req_addr} + ((ADDR_W+1)'(1) << bus.req_size) - (ADDR_W+1)'(1);
    crosses  = |be_hi;
    size_err = (32'd1 << bus.req_size) > 32'(NB);
    err      = size_err || end_addr[ADDR_W] || (end_addr >= (ADDR_W+1)'(LIMIT));
`ifndef DATA_MEM_SPLIT_EN
    err      = err || crosses;
`endif
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          state_d = RESP;
`ifdef DATA_MEM_SPLIT_EN
          if (!err && crosses) state_d = SECOND;
`endif
        end
      end
`ifdef DATA_MEM_SPLIT_EN
      SECOND: state_d = RESP;
`endif
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Storage and split-access context; intentionally survive reset.
  always_ff @(posedge clk) begin
    if (accept && !err && bus.req_write) begin
      for (int b = 0; b < int'(NB); b++) begin
        if (be_lo[b]) mem[req_idx][8*b +: 8] <= wdata_lo[8*b +: 8];
      end
    end
`ifdef DATA_MEM_SPLIT_EN
    if (accept) begin
      sec_write_q <= bus.req_write;
      sec_size_q  <= bus.req_size;
      sec_uns_q   <= bus.req_unsigned;
      sec_off_q   <= req_off;
      sec_idx_q   <= req_idx + IDXW'(1);
      sec_wdata_q <= bus.req_wdata;
      sec_lo_q    <= mem[req_idx];
    end
    if ((state_q == SECOND) && sec_write_q) begin
      for (int b = 0; b < int'(NB); b++) begin
        if (be_hi[b]) mem[sec_idx_q][8*b +: 8] <= wdata_hi[8*b +: 8];
      end
    end
`endif
  end

  // FSM state and response registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rsp_err_q   <= err;
        rsp_rdata_q <= (err || bus.req_write || crosses) ? '0 : ld_data;
      end
`ifdef DATA_MEM_SPLIT_EN
      if (state_q == SECOND) begin
        rsp_err_q   <= 1'b0;
        rsp_rdata_q <= sec_write_q ? '0 : ld_data;
      end
`endif
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_split.sv
// Self-checking bench for data_mem_split (XLEN=64, DEPTH=8) against a
// byte-array reference model. Works with or without DATA_MEM_SPLIT_EN.
module tb_data_mem_split;
  import data_mem_pkg::*;

  localparam int LIMIT = 64;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;
  logic [63:0] last_rd;
  logic [7:0]  ref_mem [LIMIT];

  data_mem_split_if #(.XLEN(64), .ADDR_W(64)) bus ();

  data_mem_split #(.XLEN(64), .DEPTH(8), .ADDR_W(64)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before timeout");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  function automatic bit model_cross(input logic [1:0] sz, input logic [63:0] addr);
    int nb = 1 << sz;
    return (int'(addr % 8) + nb) > 8;
  endfunction

  function automatic bit model_err(input logic [1:0] sz, input logic [63:0] addr);
    int nb = 1 << sz;
    if (addr > 64'(LIMIT - nb)) return 1'b1;
`ifndef DATA_MEM_SPLIT_EN
    if (model_cross(sz, addr)) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [63:0] model_load(input logic [1:0] sz, input bit uns,
                                             input logic [63:0] addr);
    int nb = 1 << sz;
    int a = int'(addr);
    logic [63:0] v = 64'd0;
    for (int k = nb - 1; k >= 0; k--) v = (v << 8) | 64'(ref_mem[a + k]);
    if (!uns && nb < 8 && v[8*nb-1]) v = v | (~64'd0 << (8 * nb));
    return v;
  endfunction

  task automatic txn(input bit wr, input logic [1:0] sz, input bit uns,
                     input logic [63:0] addr, input logic [63:0] wd, input string tag);
    logic [63:0] exp_rd;
    bit exp_err;
    int exp_lat, lat;
    exp_err = model_err(sz, addr);
    exp_lat = (!exp_err && model_cross(sz, addr)) ? 2 : 1;
    exp_rd  = (exp_err || wr) ? 64'd0 : model_load(sz, uns, addr);
    @(negedge clk);
    check({tag, "/req_ready"}, 64'(bus.req_ready), 64'd1);
    bus.req_valid    = 1'b1;
    bus.req_write    = wr;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    @(posedge clk);
    @(negedge clk);
    // Scramble fields after acceptance; the block must have registered them.
    bus.req_valid    = 1'b0;
    bus.req_write    = ~wr;
    bus.req_size     = 2'($urandom);
    bus.req_unsigned = ~uns;
    bus.req_addr     = {$urandom, $urandom};
    bus.req_wdata    = {$urandom, $urandom};
    lat = 1;
    while (!bus.rsp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    last_rd = bus.rsp_rdata;
    check({tag, "/latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "/rsp_err"}, 64'(bus.rsp_err), 64'(exp_err));
    check({tag, "/rsp_rdata"}, bus.rsp_rdata, exp_rd);
    if (!exp_err && wr) begin
      for (int k = 0; k < (1 << sz); k++) ref_mem[int'(addr) + k] = wd[8*k +: 8];
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "/back_to_idle"}, 64'(bus.rsp_valid), 64'd0);
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    logic [63:0] exp_v;
    logic [1:0]  sz;
    logic [63:0] addr;
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 64'd0;
    bus.req_wdata    = 64'd0;
    bus.rsp_ready    = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst/rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst/rsp_rdata", bus.rsp_rdata, 64'd0);
    check("rst/rsp_err", 64'(bus.rsp_err), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst/req_ready", 64'(bus.req_ready), 64'd1);

    // Give every byte a known value.
    for (int w = 0; w < 8; w++) txn(1'b1, SZ_D, 1'b0, 64'(w * 8), {$urandom, $urandom}, "init");

    // Directed scenarios.
    txn(1'b1, SZ_D, 1'b0, 64'd8, 64'h1122334455667788, "st_d8");
    txn(1'b0, SZ_D, 1'b0, 64'd8, 64'd0, "ld_d8");
    check("ld_d8/const", last_rd, 64'h1122334455667788);
    txn(1'b1, SZ_B, 1'b0, 64'd16, 64'h80, "st_b16");
    txn(1'b0, SZ_B, 1'b0, 64'd16, 64'd0, "ld_b16_s");
    check("ld_b16_s/const", last_rd, 64'hFFFFFFFFFFFFFF80);
    txn(1'b0, SZ_B, 1'b1, 64'd16, 64'd0, "ld_b16_u");
    check("ld_b16_u/const", last_rd, 64'h0000000000000080);
    txn(1'b0, SZ_D, 1'b0, 64'd60, 64'd0, "ld_d60_err");
    txn(1'b1, SZ_D, 1'b0, 64'd60, 64'hDEADBEEFDEADBEEF, "st_d60_err");
    txn(1'b1, SZ_W, 1'b0, 64'd6, 64'hAABBCCDD, "st_w6");
    txn(1'b0, SZ_W, 1'b1, 64'd6, 64'd0, "ld_w6");
`ifdef DATA_MEM_SPLIT_EN
    check("ld_w6/const", last_rd, 64'h00000000AABBCCDD);
`endif
    txn(1'b0, SZ_H, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'd0, "ld_h_wrap");

    // Backpressure: response held stable, new requests ignored.
    exp_v = model_load(SZ_D, 1'b0, 64'd8);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_size  = SZ_D;
    bus.req_addr  = 64'd8;
    @(posedge clk);
    @(negedge clk);
    bus.req_write = 1'b1;
    bus.req_addr  = 64'd0;
    bus.req_wdata = 64'hBADBADBADBADBAD0;
    for (int i = 0; i < 3; i++) begin
      check("bp/rsp_valid", 64'(bus.rsp_valid), 64'd1);
      check("bp/rsp_rdata", bus.rsp_rdata, exp_v);
      check("bp/req_ready", 64'(bus.req_ready), 64'd0);
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp/rsp_valid_drop", 64'(bus.rsp_valid), 64'd0);
    check("bp/req_ready_back", 64'(bus.req_ready), 64'd1);
    bus.rsp_ready = 1'b0;

    // Reset while a response is pending clears it at once.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_size  = SZ_D;
    bus.req_addr  = 64'd16;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check("rst_resp/pre_valid", 64'(bus.rsp_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    check("rst_resp/rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_resp/rsp_rdata", bus.rsp_rdata, 64'd0);
    check("rst_resp/req_ready", 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    reset_n = 1'b1;

`ifdef DATA_MEM_SPLIT_EN
    // Reset during SECOND of a split store: only first-word bytes land.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_size  = SZ_W;
    bus.req_addr  = 64'd6;
    bus.req_wdata = 64'h55667788;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("rst_sec/rsp_valid", 64'(bus.rsp_valid), 64'd0);
    @(negedge clk);
    check("rst_sec/rsp_valid_hold", 64'(bus.rsp_valid), 64'd0);
    reset_n = 1'b1;
    ref_mem[6] = 8'h88;
    ref_mem[7] = 8'h77;
`endif

    // Random traffic against the model.
    for (int i = 0; i < 60; i++) begin
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) addr = 64'hFFFFFFFFFFFFFFF8 + 64'($urandom_range(0, 7));
      else addr = 64'($urandom_range(0, 67));
      txn(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), addr,
          {$urandom, $urandom}, $sformatf("rnd%0d", i));
    end

    // Full storage sweep.
    for (int w = 0; w < 8; w++) txn(1'b0, SZ_D, 1'b0, 64'(w * 8), 64'd0, $sformatf("sweep%0d", w));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
